// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM state encoding and opcode classifiers for multi_cycle_cpu
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  function automatic logic writes_rd(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_LD)) || (op == OP_ADDI);
  endfunction

  function automatic logic updates_flags(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_ADDI);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hC) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - NREGS x DATA_W register file, two async read ports, one sync write port
module cpu_regfile #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/multi_cycle_cpu.sv
// rtl/multi_cycle_cpu.sv - multi-cycle core: DECODE/EXEC/MEM/WB FSM, ALU, Z/C flags, req/ack data port
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 2,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            ir_1,
  input  logic [REG_ADDR_W-1:0] ir_2,
  input  logic [REG_ADDR_W-1:0] ir_3,
  input  logic [DATA_W-1:0]     ir_imm,
  output logic                  mem_req,
  output logic                  memReadWrite,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  done,
  output logic                  illegal,
  output logic                  halted,
  output logic                  flag_z,
  output logic                  flag_c
);

  localparam int SH_W = $clog2(DATA_W);

  state_t                state, state_next;
  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] rd_idx, rs_idx;
  logic [DATA_W-1:0]     imm, a, b, res, alu_res;
  logic [DATA_W-1:0]     rd_data, rs_data;
  logic                  res_c, alu_c, st_done, rf_we;
  logic [DATA_W:0]       wide;
  logic [SH_W-1:0]       sh;

  assign rf_we = (state == S_WB) && writes_rd(op);

  cpu_regfile #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (reset),
    .raddr_a(rd_idx),
    .rdata_a(rd_data),
    .raddr_b(rs_idx),
    .rdata_b(rs_data),
    .we     (rf_we),
    .waddr  (rd_idx),
    .wdata  (res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (instr_valid) state_next = S_DECODE;
      S_DECODE: state_next = (op == OP_HALT) ? S_HALTED : S_EXEC;
      S_EXEC:   state_next = ((op == OP_LD) || (op == OP_ST)) ? S_MEM : S_WB;
      S_MEM:    if (mem_ack) state_next = (op == OP_LD) ? S_WB : S_IDLE;
      S_WB:     state_next = S_IDLE;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase
  end

  // The extra bit of 'wide' carries the carry-out or the last bit shifted out.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    wide    = '0;
    sh      = b[SH_W-1:0];
    case (op)
      OP_ADD:  begin wide = {1'b0, a} + {1'b0, b};   alu_res = wide[DATA_W-1:0]; alu_c = wide[DATA_W]; end
      OP_SUB:  begin alu_res = a - b;                alu_c = (a < b); end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  begin wide = {1'b0, a} << sh;         alu_res = wide[DATA_W-1:0]; alu_c = wide[DATA_W]; end
      OP_SHR:  begin wide = {a, 1'b0} >> sh;         alu_res = wide[DATA_W:1];   alu_c = wide[0]; end
      OP_LDI:  alu_res = imm;
      OP_ADDI: begin wide = {1'b0, b} + {1'b0, imm}; alu_res = wide[DATA_W-1:0]; alu_c = wide[DATA_W]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op      <= '0;
      rd_idx  <= '0;
      rs_idx  <= '0;
      imm     <= '0;
      a       <= '0;
      b       <= '0;
      res     <= '0;
      res_c   <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      st_done <= 1'b0;
    end else begin
      st_done <= (state == S_MEM) && mem_ack && (op == OP_ST);
      case (state)
        S_IDLE: if (instr_valid) begin
          op     <= ir_1;
          rd_idx <= ir_2;
          rs_idx <= ir_3;
          imm    <= ir_imm;
        end
        S_DECODE: begin
          a <= rd_data;
          b <= rs_data;
        end
        S_EXEC: begin
          res   <= alu_res;
          res_c <= alu_c;
        end
        S_MEM: if (mem_ack && (op == OP_LD)) res <= mem_rdata;
        S_WB: if (updates_flags(op)) begin
          flag_z <= (res == '0);
          flag_c <= res_c;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready  = (state == S_IDLE);
  assign mem_req      = (state == S_MEM);
  assign memReadWrite = mem_req && (op == OP_ST);
  assign mem_addr     = b[ADDR_W-1:0] + imm[ADDR_W-1:0];
  assign mem_wdata    = a;
  assign done         = (state == S_WB) || st_done;
  assign illegal      = (state == S_WB) && is_illegal(op);
  assign halted       = (state == S_HALTED);

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb/tb_multi_cycle_cpu.sv - randomized and directed bench for multi_cycle_cpu against a behavioural model
module tb_multi_cycle_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  ir_1;
  logic [1:0]  ir_2, ir_3;
  logic [15:0] ir_imm;
  logic        mem_req, memReadWrite;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        done, illegal, halted, flag_z, flag_c;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] m_reg [4];
  logic        m_z, m_c;
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  multi_cycle_cpu #(.DATA_W(16), .REG_ADDR_W(2), .ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ir_1        (ir_1),
    .ir_2        (ir_2),
    .ir_3        (ir_3),
    .ir_imm      (ir_imm),
    .mem_req     (mem_req),
    .memReadWrite(memReadWrite),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .done        (done),
    .illegal     (illegal),
    .halted      (halted),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0;
    m_z = 1'b0;
    m_c = 1'b0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) check("ready_timeout", 0, 1);
  endtask

  // Issue one instruction and follow it to retirement; model expectations come first.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [15:0] imm, input int ack_wait, input bit hold_valid);
    int a, b, sh, full, n, reqcnt, exp_lat;
    logic [15:0] e_res, e_wdata;
    logic [7:0]  e_addr;
    bit e_c, e_wr, e_flags, is_mem, e_ill, got_done;
    a = int'(m_reg[rd]);
    b = int'(m_reg[rs]);
    sh = b % 16;
    e_wr = 1'b1; e_flags = 1'b1; e_c = 1'b0; e_res = 16'h0;
    e_addr  = 8'((b + int'(imm)) % 256);
    e_wdata = m_reg[rd];
    is_mem  = (op == 4'h9) || (op == 4'hA);
    e_ill   = (op >= 4'hC) && (op <= 4'hE);
    case (op)
      4'h1: begin full = a + b; e_res = 16'(full % 65536); e_c = (full >= 65536); end
      4'h2: begin e_res = 16'((a - b + 65536) % 65536); e_c = (a < b); end
      4'h3: e_res = 16'(a & b);
      4'h4: e_res = 16'(a | b);
      4'h5: e_res = 16'(a ^ b);
      4'h6: begin full = a << sh; e_res = 16'(full % 65536);
                  e_c = (sh != 0) && (((a >> (16 - sh)) & 1) != 0); end
      4'h7: begin e_res = 16'(a >> sh);
                  e_c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
      4'h8: begin e_res = imm; e_flags = 1'b0; end
      4'h9: begin e_res = mem[e_addr]; e_flags = 1'b0; end
      4'hB: begin full = b + int'(imm); e_res = 16'(full % 65536); e_c = (full >= 65536); end
      default: begin e_wr = 1'b0; e_flags = 1'b0; end
    endcase
    exp_lat = is_mem ? 3 + ack_wait : 3;

    wait_ready();
    ir_1 = op; ir_2 = rd; ir_3 = rs; ir_imm = imm; instr_valid = 1'b1;
    @(negedge clk);
    if (hold_valid) begin ir_1 = 4'h1; ir_2 = rd; ir_3 = rd; ir_imm = 16'h0; end
    else instr_valid = 1'b0;

    n = 0; reqcnt = 0; got_done = 1'b0;
    while (n < 60 && !got_done) begin
      if (n > 0) @(negedge clk);
      n++;
      mem_ack = 1'b0;
      if (done) begin
        got_done = 1'b1;
        instr_valid = 1'b0;
        check("latency", n, exp_lat);
        check("illegal", illegal, e_ill);
      end else if (mem_req) begin
        reqcnt++;
        if (reqcnt == 1) begin
          check("mem_rw", memReadWrite, (op == 4'hA));
          check("mem_addr", mem_addr, e_addr);
          if (op == 4'hA) check("mem_wdata", mem_wdata, e_wdata);
        end
        if (hold_valid) check("ready_in_mem", instr_ready, 0);
        if (reqcnt == ack_wait) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
        end
      end
    end
    mem_ack = 1'b0;
    instr_valid = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
    if (is_mem) check("req_cycles", reqcnt, ack_wait);

    if (e_wr) m_reg[rd] = e_res;
    if (e_flags) begin m_z = (e_res == 16'h0); m_c = e_c; end
    if (op == 4'hA) mem[e_addr] = e_wdata;

    @(negedge clk);
    check("done_pulse", done, 0);
    check("flag_z", flag_z, m_z);
    check("flag_c", flag_c, m_c);
  endtask

  // Registers are observed by storing each one and checking the write data.
  task automatic dump_regs();
    for (int r = 0; r < 4; r++) issue(4'hA, 2'(r), 2'd0, 16'h80 + 16'(r), 1, 1'b0);
  endtask

  initial begin
    int cnt;
    reset = 1'b0; instr_valid = 1'b0; ir_1 = '0; ir_2 = '0; ir_3 = '0; ir_imm = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h20] = 16'hBEEF;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_rw", memReadWrite, 0);
    check("rst_done", done, 0);
    check("rst_halted", halted, 0);
    check("rst_flags", {flag_z, flag_c}, 0);
    reset = 1'b1;
    @(negedge clk);

    issue(4'h8, 2'd1, 2'd0, 16'hFFFF, 1, 1'b0);
    issue(4'h8, 2'd2, 2'd0, 16'h0001, 1, 1'b0);
    issue(4'h1, 2'd1, 2'd2, 16'h0, 1, 1'b0);
    check("t1_z", flag_z, 1);
    check("t1_c", flag_c, 1);

    issue(4'h8, 2'd1, 2'd0, 16'h0002, 1, 1'b0);
    issue(4'h2, 2'd2, 2'd1, 16'h0, 1, 1'b0);
    check("t2_sub_flags", {flag_z, flag_c}, 2'b01);
    issue(4'h3, 2'd2, 2'd0, 16'h0, 1, 1'b0);
    check("t2_and_flags", {flag_z, flag_c}, 2'b10);

    issue(4'h8, 2'd2, 2'd0, 16'h0010, 1, 1'b0);
    issue(4'h8, 2'd1, 2'd0, 16'h1234, 1, 1'b0);
    issue(4'hA, 2'd1, 2'd2, 16'h0004, 5, 1'b0);
    check("t3_mem", mem[8'h14], 16'h1234);

    issue(4'h9, 2'd3, 2'd0, 16'h0020, 3, 1'b1);
    dump_regs();
    check("t4_r3", m_reg[3], 16'hBEEF);

    for (int k = 0; k < 150; k++) begin
      issue(4'($urandom_range(0, 11)), 2'($urandom), 2'($urandom),
            16'($urandom), int'($urandom_range(1, 4)), 1'b0);
      if (k % 15 == 14) dump_regs();
    end

    issue(4'hD, 2'd1, 2'd2, 16'h5555, 1, 1'b0);
    dump_regs();

    wait_ready();
    ir_1 = 4'hF; ir_2 = 2'd0; ir_3 = 2'd0; ir_imm = 16'h0; instr_valid = 1'b1;
    @(negedge clk);
    ir_1 = 4'h8; ir_2 = 2'd1; ir_imm = 16'h7777;
    cnt = 0;
    while (!halted && cnt < 10) begin @(negedge clk); cnt++; end
    check("halted", halted, 1);
    check("halt_ready", instr_ready, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || instr_ready) cnt++;
    end
    check("halt_ignored", cnt, 0);
    check("halt_level", halted, 1);
    instr_valid = 1'b0;

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check("rel_halted", halted, 0);
    issue(4'h8, 2'd2, 2'd0, 16'h0030, 1, 1'b0);
    wait_ready();
    ir_1 = 4'hA; ir_2 = 2'd2; ir_3 = 2'd2; ir_imm = 16'h1; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    cnt = 0;
    while (!mem_req && cnt < 10) begin @(negedge clk); cnt++; end
    check("t6_req_up", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_req_drop", mem_req, 0);
    check("t6_ready", instr_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("t6_flags", {flag_z, flag_c}, 0);
    dump_regs();
    issue(4'h8, 2'd1, 2'd0, 16'h0003, 1, 1'b0);
    issue(4'h8, 2'd2, 2'd0, 16'h0005, 1, 1'b0);
    issue(4'h1, 2'd1, 2'd2, 16'h0, 1, 1'b0);
    dump_regs();
    check("t6_r1", m_reg[1], 16'h0008);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
